// File: rtl/led_shift_driver_pkg.sv
// led_shift_driver_pkg: state encoding, default frame width and helpers for the LED shift driver
package led_shift_driver_pkg;
  localparam int LED_WIDTH = 16;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/led_shift_driver_sr_tick_gen.sv
// sr_tick_gen: phase timer, pulses tick on the last cycle of each period-long phase
module sr_tick_gen #(
  parameter int MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [$clog2(MAX+1)-1:0]   period,
  output logic                       tick
);
  logic [$clog2(MAX+1)-1:0] div_cnt;
  assign tick = !clr && div_cnt == period - 1'b1;
  // tick also restarts the count, so every state entered on a tick starts from zero
  always_ff @(posedge clk or negedge rst)
    if (!rst) div_cnt <= '0;
    else div_cnt <= (clr || tick) ? '0 : div_cnt + 1'b1;
endmodule

// File: rtl/led_shift_driver.sv
// led_shift_driver: serialises the LED pattern into a 74HC595-style chain, resending only on change or refresh
module led_shift_driver
  import led_shift_driver_pkg::*;
#(
  parameter int WIDTH        = LED_WIDTH,
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 2,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] led_in,
  input  logic             force_refresh,
  output logic             sr_clk,
  output logic             sr_data,
  output logic             sr_latch,
  output logic             sr_oe_n,
  output logic             busy,
  output logic             frame_done
);
  localparam int TMAX = max_int(CLK_DIV, LATCH_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(WIDTH + 1);
  state_t state, state_n;
  logic [WIDTH-1:0] shreg, snapshot, last_sent, shreg_sh;
  logic [BW-1:0] bit_cnt;
  logic [TW-1:0] period;
  logic refresh_pend, init_pend, req, tick, last_bit;
  assign req      = init_pend || refresh_pend || force_refresh || led_in != last_sent;
  assign last_bit = bit_cnt == BW'(WIDTH - 1);
  assign shreg_sh = MSB_FIRST ? shreg << 1 : shreg >> 1;
  assign period   = state == LATCH ? TW'(LATCH_CYCLES) : TW'(CLK_DIV);
  sr_tick_gen #(.MAX(TMAX)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE),
    .period (period),
    .tick   (tick)
  );
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = req ? SHIFT_LO : IDLE;
    else if (tick) state_n = state == SHIFT_LO ? SHIFT_HI : state == SHIFT_HI ? (last_bit ? LATCH : SHIFT_LO) : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      shreg        <= '0;
      snapshot     <= '0;
      last_sent    <= '0;
      bit_cnt      <= '0;
      refresh_pend <= 1'b0;
      init_pend    <= 1'b1;
      sr_clk       <= 1'b0;
      sr_data      <= 1'b0;
      sr_latch     <= 1'b0;
      sr_oe_n      <= 1'b1;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state      <= state_n;
      frame_done <= 1'b0;
      if (force_refresh && state != IDLE) refresh_pend <= 1'b1;
      if (state == IDLE && req) begin
        shreg        <= led_in;
        snapshot     <= led_in;
        bit_cnt      <= '0;
        sr_data      <= MSB_FIRST ? led_in[WIDTH-1] : led_in[0];
        busy         <= 1'b1;
        init_pend    <= 1'b0;
        refresh_pend <= 1'b0;
      end
      if (state == SHIFT_LO && tick) sr_clk <= 1'b1;
      // data only moves on the falling sr_clk edge so it is stable for the whole high phase
      if (state == SHIFT_HI && tick) begin
        sr_clk <= 1'b0;
        if (last_bit) sr_latch <= 1'b1;
        else begin
          bit_cnt <= bit_cnt + 1'b1;
          shreg   <= shreg_sh;
          sr_data <= MSB_FIRST ? shreg_sh[WIDTH-1] : shreg_sh[0];
        end
      end
      if (state == LATCH && tick) begin
        sr_latch   <= 1'b0;
        last_sent  <= snapshot;
        frame_done <= 1'b1;
        sr_oe_n    <= 1'b0;
        busy       <= 1'b0;
      end
    end
endmodule

// File: tb/tb_led_shift_driver.sv
// tb_led_shift_driver: scoreboard bench, frames captured on sr_clk rises and matched against queued patterns
module tb_led_shift_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] led_in = 16'h0000;
  logic force_refresh = 1'b0;
  logic sr_clk, sr_data, sr_latch, sr_oe_n, busy, frame_done;
  led_shift_driver dut (
    .clk           (clk),
    .rst           (rst),
    .led_in        (led_in),
    .force_refresh (force_refresh),
    .sr_clk        (sr_clk),
    .sr_data       (sr_data),
    .sr_latch      (sr_latch),
    .sr_oe_n       (sr_oe_n),
    .busy          (busy),
    .frame_done    (frame_done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] led;
    logic        refresh;
    logic        expect_frame;
  } vec_t;
  vec_t tbl[8];
  int vectors = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cap = '0;
  logic held = 1'b0;
  logic prev_clk = 1'b0;
  logic unstable = 1'b0;
  int nbits = 0;
  int lat_len = 0;
  int edges = 0;
  int frames = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  // monitor: rebuild each frame from sr_clk rises, pop the expected pattern when it latches
  always @(negedge clk) begin
    if (!rst) begin
      cap = '0;
      nbits = 0;
      unstable = 1'b0;
      lat_len = 0;
      prev_clk = 1'b0;
    end else begin
      if (sr_clk && !prev_clk) begin
        cap = {cap[14:0], sr_data};
        held = sr_data;
        nbits++;
        edges++;
      end else if (sr_clk && sr_data !== held) unstable = 1'b1;
      if (sr_latch) lat_len++;
      if (frame_done) begin
        frames++;
        check("frame expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("frame data", 32'(cap), 32'(exp_q.pop_front()));
        check("frame bits", 32'(nbits), 32'd16);
        check("latch width", 32'(lat_len), 32'd2);
        check("data stable while sr_clk high", 32'(unstable), 32'd0);
        check("oe after frame", 32'(sr_oe_n), 32'd0);
        check("busy at frame_done", 32'(busy), 32'd0);
        nbits = 0;
        lat_len = 0;
        unstable = 1'b0;
      end
      prev_clk = sr_clk;
    end
  end
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1 force_refresh = 1'b0;
      @(negedge clk);
    end while (!frame_done && n < 400);
    check("frame_done within bound", 32'(frame_done), 32'd1);
    #1;
  endtask
  task automatic idle_check(input int cyc, input string name);
    int f0, e0, b;
    f0 = frames;
    e0 = edges;
    b = 0;
    repeat (cyc) begin
      @(posedge clk);
      #1 force_refresh = 1'b0;
      @(negedge clk);
      if (busy) b++;
    end
    #1;
    check({name, " frames"}, 32'(frames - f0), 32'd0);
    check({name, " sr_clk rises"}, 32'(edges - e0), 32'd0);
    check({name, " busy cycles"}, 32'(b), 32'd0);
  endtask
  task automatic apply(input logic [15:0] led, input logic refresh, input logic expect_frame, input string name);
    int n;
    @(posedge clk);
    #1 led_in = led;
    force_refresh = refresh;
    if (expect_frame) begin
      exp_q.push_back(led);
      wait_frame(n);
      check({name, " latency"}, 32'(n), 32'd131);
    end else idle_check(150, name);
    check({name, " scoreboard drained"}, 32'(exp_q.size()), 32'd0);
  endtask
  initial begin
    int n;
    tbl[0] = '{16'hA5C3, 1'b0, 1'b1};
    tbl[1] = '{16'hA5C3, 1'b0, 1'b0};
    tbl[2] = '{16'hA5C3, 1'b1, 1'b1};
    tbl[3] = '{16'h00FF, 1'b1, 1'b1};
    tbl[4] = '{16'h00FF, 1'b0, 1'b0};
    tbl[5] = '{16'hFFFF, 1'b0, 1'b1};
    tbl[6] = '{16'h8001, 1'b0, 1'b1};
    tbl[7] = '{16'h0001, 1'b0, 1'b1};
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset sr_clk", 32'(sr_clk), 32'd0);
    check("reset sr_data", 32'(sr_data), 32'd0);
    check("reset sr_latch", 32'(sr_latch), 32'd0);
    check("reset sr_oe_n", 32'(sr_oe_n), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    exp_q.push_back(16'h0000);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("init busy", 32'(busy), 32'd1);
    check("init oe still blanked", 32'(sr_oe_n), 32'd1);
    wait_frame(n);
    check("init latency", 32'(n + 100), 32'd131);
    for (int i = 0; i < 8; i++) apply(tbl[i].led, tbl[i].refresh, tbl[i].expect_frame, $sformatf("vec%0d", i));
    apply(16'h00FF, 1'b0, 1'b1, "set 00FF");
    idle_check(1000, "stable 1000");
    apply(16'h00FF, 1'b1, 1'b1, "refresh after idle");
    @(posedge clk);
    #1 led_in = 16'h0001;
    exp_q.push_back(16'h0001);
    repeat (40) @(posedge clk);
    #1 led_in = 16'h0003;
    exp_q.push_back(16'h0003);
    wait_frame(n);
    check("mid-frame change first", 32'(n), 32'd91);
    wait_frame(n);
    check("back-to-back latency", 32'(n), 32'd131);
    check("mid-frame scoreboard", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1 force_refresh = 1'b1;
    exp_q.push_back(16'h0003);
    @(posedge clk);
    #1 force_refresh = 1'b0;
    for (int k = 0; k < 2; k++) begin
      repeat (20) @(posedge clk);
      #1 force_refresh = 1'b1;
      @(posedge clk);
      #1 force_refresh = 1'b0;
    end
    exp_q.push_back(16'h0003);
    wait_frame(n);
    wait_frame(n);
    check("pending refresh latency", 32'(n), 32'd131);
    idle_check(200, "no third frame");
    check("refresh scoreboard", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1 led_in = 16'h1234;
    exp_q.push_back(16'h1234);
    repeat (60) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midreset sr_clk", 32'(sr_clk), 32'd0);
    check("midreset sr_latch", 32'(sr_latch), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset sr_oe_n", 32'(sr_oe_n), 32'd1);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.push_back(16'h1234);
    wait_frame(n);
    check("post-reset latency", 32'(n), 32'd131);
    check("post-reset scoreboard", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
